// File: rtl/lfo_pkg.sv
// Shared types and the elaboration-time sine table generator for the multi-channel LFO.
package lfo_pkg;

  typedef enum logic [1:0] {
    SINE   = 2'd0,
    TRI    = 2'd1,
    SAW    = 2'd2,
    SQUARE = 2'd3
  } wave_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    DRAIN   = 2'd2,
    PUBLISH = 2'd3
  } state_e;

  localparam int unsigned DRAIN_CYCLES = 3;

  // Bhaskara rational sine approximation; exact at 0, 1/4, 1/2 and 3/4 turn.
  // ROM contents are built at elaboration, so no external hex image is needed.
  function automatic int sine_entry(int unsigned aw, int unsigned dw, int unsigned idx);
    longint half;
    longint amp;
    longint i;
    longint num;
    longint den;
    bit     neg;
    half = longint'(1) << (aw - 1);
    amp  = (longint'(1) << (dw - 1)) - 1;
    i    = longint'(idx);
    neg  = (i >= half);
    if (neg) i = i - half;
    num  = 16 * amp * i * (half - i);
    den  = 5 * half * half - 4 * i * (half - i);
    return neg ? -int'(num / den) : int'(num / den);
  endfunction

endpackage

// File: rtl/lfo_wave_shaper.sv
// Sine ROM and waveform select (registered S2) followed by the depth scaler (combinational S3).
module lfo_wave_shaper
  import lfo_pkg::*;
#(
  parameter int unsigned LUT_AW  = 8,
  parameter int unsigned LUT_DW  = 14,
  parameter int unsigned OUT_W   = 14,
  parameter int unsigned SCALE_W = 4,
  parameter int unsigned CH_W    = 1,
  parameter int unsigned PH_W    = LUT_DW + 1
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               s1_vld,
  input  logic [CH_W-1:0]    s1_ch,
  input  logic [PH_W-1:0]    s1_phase,
  input  wave_e              wave_sel,
  input  logic [SCALE_W-1:0] scale,
  output logic               s2_vld,
  output logic [CH_W-1:0]    s2_ch,
  output logic [OUT_W-1:0]   sample_c
);

  localparam int unsigned PROD_W = LUT_DW + SCALE_W + 1;
  localparam logic signed [LUT_DW-1:0] POS_FS = {1'b0, {(LUT_DW-1){1'b1}}};
  localparam logic signed [LUT_DW-1:0] NEG_FS = -POS_FS;

  logic signed [LUT_DW-1:0] rom [2**LUT_AW];

  for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
    assign rom[i] = LUT_DW'(sine_entry(LUT_AW, LUT_DW, i));
  end

  logic        [LUT_DW-1:0] saw_c;
  logic        [LUT_DW:0]   tri_t_c;
  logic        [LUT_DW-1:0] tri_f_c;
  logic signed [LUT_DW-1:0] shape_c;
  logic signed [LUT_DW-1:0] s2_rom_q;
  logic signed [LUT_DW-1:0] s2_shape_q;

  // Non-sine shapes; subtracting half-scale is an MSB flip of the unsigned ramp.
  always_comb begin
    saw_c   = s1_phase[PH_W-1 -: LUT_DW];
    tri_t_c = s1_phase[PH_W-1 -: LUT_DW+1];
    tri_f_c = tri_t_c[LUT_DW] ? ~tri_t_c[LUT_DW-1:0] : tri_t_c[LUT_DW-1:0];
    shape_c = '0;
    case (wave_sel)
      TRI:     shape_c = {~tri_f_c[LUT_DW-1], tri_f_c[LUT_DW-2:0]};
      SAW:     shape_c = {~saw_c[LUT_DW-1], saw_c[LUT_DW-2:0]};
      SQUARE:  shape_c = s1_phase[PH_W-1] ? NEG_FS : POS_FS;
      default: shape_c = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_vld     <= 1'b0;
      s2_ch      <= '0;
      s2_rom_q   <= '0;
      s2_shape_q <= '0;
    end else begin
      s2_vld     <= s1_vld;
      s2_ch      <= s1_ch;
      s2_rom_q   <= rom[s1_phase[PH_W-1 -: LUT_AW]];
      s2_shape_q <= shape_c;
    end
  end

  logic signed [LUT_DW-1:0] x_c;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [LUT_DW-1:0] y_c;

  // All-ones depth bypasses the multiplier so unity gain stays exact.
  always_comb begin
    x_c      = (wave_sel == SINE) ? s2_rom_q : s2_shape_q;
    prod_c   = PROD_W'(x_c) * PROD_W'($signed({1'b0, scale}));
    y_c      = (scale == {SCALE_W{1'b1}}) ? x_c : LUT_DW'(prod_c >>> SCALE_W);
    sample_c = OUT_W'(y_c) << (OUT_W - LUT_DW);
  end

endmodule

// File: rtl/lfo_multi_gen.sv
// Multi-channel LFO: shared phase accumulator, per-frame FSM issuing channels through one shaper.
module lfo_multi_gen
  import lfo_pkg::*;
#(
  parameter int unsigned NUM_CH  = 2,
  parameter int unsigned PHASE_W = 32,
  parameter int unsigned LUT_AW  = 8,
  parameter int unsigned LUT_DW  = 14,
  parameter int unsigned OUT_W   = 14,
  parameter int unsigned SCALE_W = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    sample_tick_i,
  input  logic                    phase_sync_i,
  input  logic [PHASE_W-1:0]      freq_step_i,
  input  wave_e                   wave_sel_i,
  input  logic [SCALE_W-1:0]      scale_i,
  input  logic [7:0]              phase_offset_i,
  output logic [NUM_CH*OUT_W-1:0] wave_o,
  output logic                    valid_o,
  output logic                    busy_o,
  output logic                    overrun_o
);

  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (NUM_CH > DRAIN_CYCLES) ? $clog2(NUM_CH) : $clog2(DRAIN_CYCLES);
  localparam int unsigned PH_W  = (LUT_AW > LUT_DW + 1) ? LUT_AW : LUT_DW + 1;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [PHASE_W-1:0]   acc_q, base_q, base_c, off_term_c;
  wave_e                sel_q;
  logic [SCALE_W-1:0]   scale_q;
  logic [7:0]           off_q, off_acc_q;
  logic                 accept_c;
  logic                 s1_vld_q;
  logic [CH_W-1:0]      s1_ch_q;
  logic [PH_W-1:0]      s1_phase_q;
  logic                 s2_vld;
  logic [CH_W-1:0]      s2_ch;
  logic [OUT_W-1:0]     sample_c;
  logic [OUT_W-1:0]     shadow_q [NUM_CH];
  logic [NUM_CH*OUT_W-1:0] wave_q;
  logic                 valid_q, busy_q, overrun_q;

  assign accept_c   = (state_q == IDLE) && sample_tick_i;
  assign base_c     = phase_sync_i ? '0 : acc_q;
  assign off_term_c = {off_acc_q, {(PHASE_W-8){1'b0}}};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (sample_tick_i) state_d = ISSUE;
      ISSUE:   if (cnt_q == CNT_W'(NUM_CH - 1)) state_d = DRAIN;
      DRAIN:   if (cnt_q == CNT_W'(DRAIN_CYCLES - 1)) state_d = PUBLISH;
      PUBLISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; the counter restarts on every state change (channel index / drain count).
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
      busy_q  <= (state_d != IDLE);
    end
  end

  // Accumulator, frame capture and sticky overrun; a sync clear beats an overrun tick.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_q     <= '0;
      base_q    <= '0;
      sel_q     <= SINE;
      scale_q   <= '0;
      off_q     <= '0;
      off_acc_q <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (accept_c) begin
        acc_q     <= base_c + freq_step_i;
        base_q    <= base_c;
        sel_q     <= wave_sel_i;
        scale_q   <= scale_i;
        off_q     <= phase_offset_i;
        off_acc_q <= '0;
      end else begin
        if (phase_sync_i) acc_q <= '0;
        if (state_q == ISSUE) off_acc_q <= off_acc_q + off_q;
      end
      if (phase_sync_i) overrun_q <= 1'b0;
      else if (sample_tick_i && state_q != IDLE) overrun_q <= 1'b1;
    end
  end

  // S1: channel phase; the 8-bit running offset wraps mod one turn by construction.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_vld_q   <= 1'b0;
      s1_ch_q    <= '0;
      s1_phase_q <= '0;
    end else begin
      s1_vld_q   <= (state_q == ISSUE);
      s1_ch_q    <= CH_W'(cnt_q);
      s1_phase_q <= PH_W'((base_q + off_term_c) >> (PHASE_W - PH_W));
    end
  end

  lfo_wave_shaper #(
    .LUT_AW  (LUT_AW),
    .LUT_DW  (LUT_DW),
    .OUT_W   (OUT_W),
    .SCALE_W (SCALE_W),
    .CH_W    (CH_W),
    .PH_W    (PH_W)
  ) u_shaper (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .s1_vld   (s1_vld_q),
    .s1_ch    (s1_ch_q),
    .s1_phase (s1_phase_q),
    .wave_sel (sel_q),
    .scale    (scale_q),
    .s2_vld   (s2_vld),
    .s2_ch    (s2_ch),
    .sample_c (sample_c)
  );

  // S3 shadow registers, then all channels published together.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int k = 0; k < NUM_CH; k++) shadow_q[k] <= '0;
      wave_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      if (s2_vld) shadow_q[s2_ch] <= sample_c;
      valid_q <= (state_q == PUBLISH);
      if (state_q == PUBLISH) begin
        for (int k = 0; k < NUM_CH; k++) wave_q[k*OUT_W +: OUT_W] <= shadow_q[k];
      end
    end
  end

  assign wave_o    = wave_q;
  assign valid_o   = valid_q;
  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_lfo_multi_gen.sv
// Directed self-checking bench for lfo_multi_gen with default parameters (NUM_CH=2).
module tb_lfo_multi_gen;
  import lfo_pkg::*;

  localparam int unsigned NUM_CH = 2;
  localparam int unsigned OUT_W  = 14;

  typedef logic signed [31:0] val_t;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    tick;
  logic                    sync;
  logic [31:0]             step;
  wave_e                   sel;
  logic [3:0]              scale;
  logic [7:0]              off;
  logic [NUM_CH*OUT_W-1:0] wave;
  logic                    valid;
  logic                    busy;
  logic                    ovr;

  int n_cmp  = 0;
  int n_fail = 0;

  val_t saw_exp [5] = '{-8192, -4096, 0, 4096, -8192};
  // Falling-edge quarter point: t[13:0]=0x2000 inverts to 0x1FFF, one LSB below zero.
  val_t tri_exp [4] = '{-8192, 0, 8191, -1};

  always #5 clk = ~clk;

  lfo_multi_gen dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .sample_tick_i  (tick),
    .phase_sync_i   (sync),
    .freq_step_i    (step),
    .wave_sel_i     (sel),
    .scale_i        (scale),
    .phase_offset_i (off),
    .wave_o         (wave),
    .valid_o        (valid),
    .busy_o         (busy),
    .overrun_o      (ovr)
  );

  function automatic val_t chan(int k);
    logic signed [OUT_W-1:0] v;
    v = wave[k*OUT_W +: OUT_W];
    return val_t'(v);
  endfunction

  task automatic chk(input string tag, input val_t obs, input val_t exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input wave_e s, input logic [31:0] st, input logic [3:0] sc, input logic [7:0] of);
    sel = s; step = st; scale = sc; off = of;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    cyc(1);
    sync = 1'b0;
  endtask

  // One tick, bounded wait for valid, then latency / channel / status checks.
  task automatic do_frame(input string tag, input logic s, input val_t e0, input val_t e1, input bit scr);
    int lat;
    sync = s;
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    sync = 1'b0;
    if (scr) begin
      sel = SAW; scale = 4'hF; off = 8'h00; step = 32'h1234_5678;
    end
    chk({tag, "_busy"}, val_t'(busy), 1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      cyc(1);
      if (valid) begin
        lat = c;
        break;
      end
    end
    chk({tag, "_lat"}, lat, 6);
    chk({tag, "_ch0"}, chan(0), e0);
    chk({tag, "_ch1"}, chan(1), e1);
    chk({tag, "_idle"}, val_t'(busy), 0);
    cyc(1);
    chk({tag, "_vpulse"}, val_t'(valid), 0);
  endtask

  initial begin
    int   nv;
    val_t v0;
    rst_n = 1'b0; tick = 1'b0; sync = 1'b0;
    cfg(SINE, 32'h0, 4'hF, 8'h00);

    #12;
    chk("rst_wave",  val_t'(wave), 0);
    chk("rst_valid", val_t'(valid), 0);
    chk("rst_busy",  val_t'(busy), 0);
    chk("rst_ovr",   val_t'(ovr), 0);
    cyc(1);
    rst_n = 1'b1;
    cyc(1);

    // Square spread by half a turn
    cfg(SQUARE, 32'h0, 4'hF, 8'h80);
    do_frame("t1_sq", 1'b0, 8191, -8191, 1'b0);

    // Saw at quarter-turn steps, wrapping after four
    pulse_sync();
    cfg(SAW, 32'h4000_0000, 4'hF, 8'h00);
    for (int i = 0; i < 5; i++) do_frame($sformatf("t2_saw%0d", i), 1'b0, saw_exp[i], saw_exp[i], 1'b0);
    chk("t2_ovr", val_t'(ovr), 0);

    // Depth scaling (acc sits at a quarter turn); inputs scrambled mid-frame on the first
    cfg(SQUARE, 32'h0, 4'h8, 8'h80);
    do_frame("t3_sc8", 1'b0, 4095, -4096, 1'b1);
    cfg(SQUARE, 32'h0, 4'h0, 8'h80);
    do_frame("t3_sc0", 1'b0, 0, 0, 1'b0);

    // Triangle over one turn, then sine ROM at quarter points
    pulse_sync();
    cfg(TRI, 32'h4000_0000, 4'hF, 8'h00);
    for (int i = 0; i < 4; i++) do_frame($sformatf("t4_tri%0d", i), 1'b0, tri_exp[i], tri_exp[i], 1'b0);
    cfg(SINE, 32'h0, 4'hF, 8'h40);
    do_frame("t4_sin40", 1'b0, 0, 8191, 1'b0);
    cfg(SINE, 32'h0, 4'hF, 8'hC0);
    do_frame("t4_sinC0", 1'b0, 0, -8191, 1'b0);

    // Overrun: second tick two cycles into a frame
    pulse_sync();
    cfg(SAW, 32'h4000_0000, 4'hF, 8'h00);
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1); tick = 1'b1; cyc(1); tick = 1'b0;
    nv = 0; v0 = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      if (valid) begin nv++; v0 = chan(0); end
    end
    chk("t5_nvalid", nv, 1);
    chk("t5_ch0", v0, -8192);
    chk("t5_ovr", val_t'(ovr), 1);
    do_frame("t5_next", 1'b0, -4096, -4096, 1'b0);
    chk("t5_ovr_sticky", val_t'(ovr), 1);
    pulse_sync();
    chk("t5_ovr_clr", val_t'(ovr), 0);

    // Sync coinciding with an overrun tick: clear wins and acc restarts from zero
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(1); tick = 1'b1; sync = 1'b1; cyc(1); tick = 1'b0; sync = 1'b0;
    nv = 0; v0 = 0;
    for (int c = 0; c < 20; c++) begin
      cyc(1);
      if (valid) begin nv++; v0 = chan(0); end
    end
    chk("t5b_nvalid", nv, 1);
    chk("t5b_ch0", v0, -8192);
    chk("t5b_ovr", val_t'(ovr), 0);
    do_frame("t5b_after", 1'b0, -8192, -8192, 1'b0);

    // Reset three cycles into a frame discards it
    tick = 1'b1; cyc(1); tick = 1'b0; cyc(3);
    rst_n = 1'b0;
    #1;
    chk("t6_wave",  val_t'(wave), 0);
    chk("t6_busy",  val_t'(busy), 0);
    chk("t6_valid", val_t'(valid), 0);
    cyc(2);
    rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(1);
      if (valid) nv++;
    end
    chk("t6_novalid", nv, 0);
    chk("t6_ovr", val_t'(ovr), 0);
    do_frame("t6_sync", 1'b1, -8192, -8192, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
